// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the data-memory side of the arbiter.
// The master modport is the environment (requesters and memory); the slave modport is the arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  busy, grant
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output busy, grant
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// One latched request per transaction: IDLE -> ACCESS (one memory cycle) -> RESP (ack), or IDLE -> RESP on error.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WORDS_LOG2 = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              last;
  logic              gnt;
  logic              we_r;
  logic              err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              bad;

  always_comb begin
    any_req   = bus.p0_req | bus.p1_req;
    // On a tie the port that did not win last time goes; otherwise the sole requester.
    win       = (bus.p0_req & bus.p1_req) ? ~last : bus.p1_req;
    sel_we    = win ? bus.p1_we    : bus.p0_we;
    sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    bad       = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (WORDS_LOG2 + 2)) != '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = bad ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      gnt      <= 1'b0;
      we_r     <= 1'b0;
      err_r    <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata0_r <= '0;
      rdata1_r <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt     <= win;
        last    <= win;
        we_r    <= sel_we;
        addr_r  <= sel_addr;
        wdata_r <= sel_wdata;
        err_r   <= bad;
      end
      if (state == ACCESS && !we_r) begin
        if (gnt) rdata1_r <= bus.mem_rdata;
        else     rdata0_r <= bus.mem_rdata;
      end
    end
  end

  // Strobes are pure state decodes so an asynchronous reset drops them immediately.
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_write = (state == ACCESS) &  we_r;
  assign bus.mem_read  = (state == ACCESS) & ~we_r;

  assign bus.busy  = (state != IDLE);
  assign bus.grant = gnt;

  assign bus.p0_ack   = (state == RESP) & ~gnt;
  assign bus.p0_err   = (state == RESP) & ~gnt & err_r;
  assign bus.p0_rdata = rdata0_r;
  assign bus.p1_ack   = (state == RESP) &  gnt;
  assign bus.p1_err   = (state == RESP) &  gnt & err_r;
  assign bus.p1_rdata = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: requester drivers, a word memory, a transaction-level reference and a scoreboard.
module tb_dmem_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int WORDS_LOG2 = 10;
  localparam int NWORDS     = 1 << WORDS_LOG2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS_LOG2(WORDS_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  ackv;
  logic [1:0]  errv;
  logic [31:0] rdv   [2];

  assign bus.p0_req   = req[0];
  assign bus.p0_we    = we[0];
  assign bus.p0_addr  = addr[0];
  assign bus.p0_wdata = wdata[0];
  assign bus.p1_req   = req[1];
  assign bus.p1_we    = we[1];
  assign bus.p1_addr  = addr[1];
  assign bus.p1_wdata = wdata[1];
  assign ackv   = {bus.p1_ack, bus.p0_ack};
  assign errv   = {bus.p1_err, bus.p0_err};
  assign rdv[0] = bus.p0_rdata;
  assign rdv[1] = bus.p1_rdata;

  // Stand-in for dataMemory: combinational read, write on the rising edge.
  logic [31:0] mem [NWORDS];
  assign bus.mem_rdata = mem[bus.mem_addr[WORDS_LOG2+1:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[WORDS_LOG2+1:2]] <= bus.mem_wdata;

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; int unsigned dly; } op_t;
  typedef struct { int ack_cyc; logic err; logic rd; logic [31:0] rdata; } exp_t;

  op_t  opq0[$], opq1[$];
  exp_t expq0[$], expq1[$];
  int   grant_log[$];
  logic [1:0] drv_busy = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: one transaction at a time, round-robin on ties, outcome from address rules and a word array.
  int          ncyc = 0;
  logic        m_en = 1'b0;
  logic        m_last = 1'b1;
  int          next_free = 0;
  int          acc_cyc = -1;
  logic        acc_we = 1'b0;
  logic [31:0] acc_addr = '0;
  int          busy_from = -1;
  int          busy_to = -1;
  logic [31:0] refmem [NWORDS];
  int          m_c;
  int          m_p;
  exp_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 1'b1;
      next_free = 0;
      acc_cyc = -1;
      busy_from = -1;
      busy_to = -1;
      expq0.delete();
      expq1.delete();
    end else if (m_en) begin
      m_c = ncyc + 1;
      if (m_c >= next_free && req != 2'b00) begin
        m_p = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
        m_last = m_p[0];
        m_e.err = (addr[m_p][1:0] != 2'b00) || (addr[m_p] >= 4 * NWORDS);
        m_e.rd = !we[m_p];
        m_e.rdata = '0;
        m_e.ack_cyc = m_e.err ? m_c : m_c + 1;
        if (!m_e.err) begin
          acc_cyc = m_c;
          acc_we = we[m_p];
          acc_addr = addr[m_p];
          if (we[m_p]) refmem[addr[m_p][WORDS_LOG2+1:2]] = wdata[m_p];
          else m_e.rdata = refmem[addr[m_p][WORDS_LOG2+1:2]];
        end
        busy_from = m_c;
        busy_to = m_e.ack_cyc;
        next_free = m_e.ack_cyc + 2;
        if (m_p == 0) expq0.push_back(m_e);
        else expq1.push_back(m_e);
      end
    end
  end

  logic [31:0] exp_rd [2];

  task automatic check_port(input int p);
    exp_t e;
    int   n;
    logic a;
    a = ackv[p];
    n = (p == 0) ? expq0.size() : expq1.size();
    if (n == 0) begin
      if (a) chk($sformatf("p%0d_ack_unexpected", p), {31'd0, a}, 32'd0);
    end else begin
      if (p == 0) e = expq0[0];
      else e = expq1[0];
      if (a || e.ack_cyc <= ncyc) begin
        if (p == 0) e = expq0.pop_front();
        else e = expq1.pop_front();
        chk($sformatf("p%0d_ack", p), {31'd0, a}, 32'd1);
        chk($sformatf("p%0d_ack_cycle", p), ncyc, e.ack_cyc);
        if (a) begin
          chk($sformatf("p%0d_err", p), {31'd0, errv[p]}, {31'd0, e.err});
          chk($sformatf("p%0d_grant", p), {31'd0, bus.grant}, p);
          if (e.rd && !e.err) exp_rd[p] = e.rdata;
          grant_log.push_back(p);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      check_port(0);
      check_port(1);
      if (m_en) begin
        chk("mem_write", {31'd0, bus.mem_write}, {31'd0, (ncyc == acc_cyc) && acc_we});
        chk("mem_read", {31'd0, bus.mem_read}, {31'd0, (ncyc == acc_cyc) && !acc_we});
        if (ncyc == acc_cyc) chk("mem_addr", bus.mem_addr, acc_addr);
        chk("busy", {31'd0, bus.busy}, {31'd0, (ncyc >= busy_from) && (ncyc <= busy_to)});
        chk("p0_rdata", rdv[0], exp_rd[0]);
        chk("p1_rdata", rdv[1], exp_rd[1]);
      end
    end
  end

  task automatic drive_port(input int p);
    op_t op;
    int  n;
    logic got;
    forever begin
      @(posedge clk);
      if ((p == 0 ? opq0.size() : opq1.size()) == 0) continue;
      drv_busy[p] = 1'b1;
      if (p == 0) op = opq0.pop_front();
      else op = opq1.pop_front();
      repeat (op.dly) @(posedge clk);
      #1;
      we[p] = op.w;
      addr[p] = op.a;
      wdata[p] = op.d;
      req[p] = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 64) begin
        @(negedge clk);
        n++;
        got = ackv[p];
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL p%0d_ack_timeout: got no ack required ack within 64 cycles", p);
      end
      @(posedge clk);
      #1 req[p] = 1'b0;
      drv_busy[p] = 1'b0;
    end
  endtask

  initial drive_port(0);
  initial drive_port(1);

  task automatic push(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int unsigned dly);
    op_t op;
    op.w = w; op.a = a; op.d = d; op.dly = dly;
    if (p == 0) opq0.push_back(op);
    else opq1.push_back(op);
  endtask

  task automatic drain();
    int n = 0;
    while ((opq0.size() != 0 || opq1.size() != 0 || drv_busy != 2'b00 ||
            expq0.size() != 0 || expq1.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending work required none after 3000 cycles");
    end
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
    if (r == 1) return 32'h0000_1000 + 32'(4 * $urandom_range(0, 1023));
    if (r == 2) return ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
    if (r == 3) return 32'h0000_0FFC;
    return 32'(4 * $urandom_range(0, 15));
  endfunction

  initial begin
    req = '0;
    we = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      exp_rd[i] = '0;
    end
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = '0;
      refmem[i] = '0;
    end

    #2 rst_n = 1'b0;
    #10;
    chk("rst_p0_ack", {31'd0, bus.p0_ack}, 32'd0);
    chk("rst_p1_ack", {31'd0, bus.p1_ack}, 32'd0);
    chk("rst_p0_err", {31'd0, bus.p0_err}, 32'd0);
    chk("rst_p1_err", {31'd0, bus.p1_err}, 32'd0);
    chk("rst_p0_rdata", bus.p0_rdata, 32'd0);
    chk("rst_p1_rdata", bus.p1_rdata, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_grant", {31'd0, bus.grant}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset during the ACCESS cycle of a write.
    @(posedge clk);
    #1;
    we[0] = 1'b1;
    addr[0] = 32'h20;
    wdata[0] = 32'h1234_5678;
    req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_mem_write_access", {31'd0, bus.mem_write}, 32'd1);
    chk("t5_busy_access", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_write_async", {31'd0, bus.mem_write}, 32'd0);
    chk("t5_mem_read_async", {31'd0, bus.mem_read}, 32'd0);
    chk("t5_busy_async", {31'd0, bus.busy}, 32'd0);
    chk("t5_p0_ack", {31'd0, bus.p0_ack}, 32'd0);
    chk("t5_grant", {31'd0, bus.grant}, 32'd0);
    req[0] = 1'b0;
    we[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    m_en = 1'b1;

    // Simultaneous requests straight after reset: port 0 first.
    grant_log.delete();
    push(0, 1'b0, 32'h10, 32'h0, 0);
    push(1, 1'b0, 32'h10, 32'h0, 0);
    drain();
    chk("t2_ngrants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      chk("t2_first_grant", grant_log[0], 32'd0);
      chk("t2_second_grant", grant_log[1], 32'd1);
    end

    push(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    push(0, 1'b0, 32'h10, 32'h0, 0);
    drain();
    chk("t1_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);

    push(1, 1'b0, 32'h0000_1000, 32'h0, 0);
    push(1, 1'b0, 32'h0000_0006, 32'h0, 1);
    drain();

    push(1, 1'b1, 32'h3FC, 32'hA5A5_A5A5, 0);
    push(1, 1'b0, 32'h3FC, 32'h0, 0);
    push(0, 1'b1, 32'h3FC, 32'h0, 0);
    drain();

    // Both ports continuously busy: grants must alternate.
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 32'(4 * i), 32'h0, 0);
      push(1, 1'b1, 32'(4 * i + 64), 32'hC0DE_0000 + 32'(i), 0);
    end
    drain();
    chk("t3_ngrants", grant_log.size(), 32'd6);
    for (int i = 1; i < grant_log.size(); i++)
      chk($sformatf("t3_alternate_%0d", i), grant_log[i], 32'(1 - grant_log[i-1]));

    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        push(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), $urandom_range(0, 3));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
